regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port between two producers: in-order pipeline writeback (WB)
//  and the long-latency unit (LL: mul/div, load miss). Registered write command drives the regfile write port.

---
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between WB and LL producers.
// Define REGFILE_ARB_SCOREBOARD_EN to build the LL busy scoreboard and decode hazard output.
module regfile_write_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iWbValid,
  input  logic [ADDRESS_WIDTH-1:0]        iWbAddr,
  input  logic [DATA_WIDTH-1:0]           iWbData,
  output logic                            oWbReady,
  input  logic                            iLlValid,
  input  logic [ADDRESS_WIDTH-1:0]        iLlAddr,
  input  logic [DATA_WIDTH-1:0]           iLlData,
  output logic                            oLlReady,
  input  logic                            iIssueValid,
  input  logic [ADDRESS_WIDTH-1:0]        iIssueAddr,
  input  logic [ADDRESS_WIDTH-1:0]        iReadAddress1,
  input  logic [ADDRESS_WIDTH-1:0]        iReadAddress2,
  output logic                            oHazard,
  output logic [(2**ADDRESS_WIDTH)-1:0]   oBusyMask,
  output logic                            oWriteEn,
  output logic [ADDRESS_WIDTH-1:0]        oWriteAddress,
  output logic [DATA_WIDTH-1:0]           oDataIn
);

  localparam int NUM_REGS = 2**ADDRESS_WIDTH;

  typedef enum logic {
    RR_WB = 1'b0,
    RR_LL = 1'b1
  } rr_e;

  rr_e                      rr_q, rr_d;
  logic                     wb_grant, ll_grant, contested;
  logic [ADDRESS_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0]    grant_data;
  logic                     write_en_q, write_en_d;
  logic [ADDRESS_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    contested    = iWbValid & iLlValid;
    wb_grant     = ~iRst & iWbValid & (~iLlValid | (rr_q == RR_WB));
    ll_grant     = ~iRst & iLlValid & (~iWbValid | (rr_q == RR_LL));
    rr_d         = rr_q;
    if (contested) begin
      rr_d = (rr_q == RR_WB) ? RR_LL : RR_WB;
    end

    grant_addr   = ll_grant ? iLlAddr : iWbAddr;
    grant_data   = ll_grant ? iLlData : iWbData;

    // x0 completes the handshake but never reaches the register file.
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if ((wb_grant | ll_grant) && (grant_addr != '0)) begin
      write_en_d   = 1'b1;
      write_addr_d = grant_addr;
      write_data_d = grant_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rr_q         <= RR_WB;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      rr_q         <= rr_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign oWbReady      = wb_grant;
  assign oLlReady      = ll_grant;
  assign oWriteEn      = write_en_q;
  assign oWriteAddress = write_addr_q;
  assign oDataIn       = write_data_q;

  a_one_grant : assert property (@(posedge iClk) !(wb_grant && ll_grant));

`ifdef REGFILE_ARB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                issue_set, ll_clear;

  always_comb begin
    issue_set = iIssueValid && (iIssueAddr != '0);
    ll_clear  = ll_grant && (iLlAddr != '0);
    busy_d    = busy_q;
    if (ll_clear) begin
      busy_d[iLlAddr] = 1'b0;
    end
    // Applied after the clear so a same-edge re-issue keeps the register busy.
    if (issue_set) begin
      busy_d[iIssueAddr] = 1'b1;
    end
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it is cleared by reset like any other state.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign oBusyMask = busy_q;
  assign oHazard   = busy_q[iReadAddress1] | busy_q[iReadAddress2] |
                     (iIssueValid & busy_q[iIssueAddr]);

  // Re-issuing a busy register is only legal when its LL result retires on the same edge.
  a_issue_not_busy : assert property (@(posedge iClk) disable iff (iRst)
    !(issue_set && busy_q[iIssueAddr] && !(ll_clear && (iLlAddr == iIssueAddr))));
`else
  logic unused_scoreboard_inputs;

  assign unused_scoreboard_inputs = ^{iIssueValid, iIssueAddr, iReadAddress1, iReadAddress2};
  assign oBusyMask = '0;
  assign oHazard   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed spec scenarios plus randomized traffic
// against an array-based reference model; follows REGFILE_ARB_SCOREBOARD_EN like the design.
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 1 << AW;

`ifdef REGFILE_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iWbValid, iLlValid, iIssueValid;
  logic [AW-1:0] iWbAddr, iLlAddr, iIssueAddr, iReadAddress1, iReadAddress2;
  logic [DW-1:0] iWbData, iLlData;
  logic          oWbReady, oLlReady, oHazard, oWriteEn;
  logic [NR-1:0] oBusyMask;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oDataIn;

  regfile_write_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .iClk(iClk), .iRst(iRst),
    .iWbValid(iWbValid), .iWbAddr(iWbAddr), .iWbData(iWbData), .oWbReady(oWbReady),
    .iLlValid(iLlValid), .iLlAddr(iLlAddr), .iLlData(iLlData), .oLlReady(oLlReady),
    .iIssueValid(iIssueValid), .iIssueAddr(iIssueAddr),
    .iReadAddress1(iReadAddress1), .iReadAddress2(iReadAddress2),
    .oHazard(oHazard), .oBusyMask(oBusyMask),
    .oWriteEn(oWriteEn), .oWriteAddress(oWriteAddress), .oDataIn(oDataIn)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: WB-priority flag, pending-register array, expected write port.
  bit            m_wb_turn;
  bit            m_busy [NR];
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            exp_wb_ready, exp_ll_ready, exp_hazard;
  logic          obs_wb_ready, obs_ll_ready, obs_hazard;

  function automatic logic [NR-1:0] model_mask();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_wb_turn = 1'b1;
    m_we      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    iWbValid = 0; iWbAddr = '0; iWbData = '0;
    iLlValid = 0; iLlAddr = '0; iLlData = '0;
    iIssueValid = 0; iIssueAddr = '0;
    iReadAddress1 = '0; iReadAddress2 = '0;
  endtask

  // Inputs are applied just after a posedge; sample combinational outputs at the negedge,
  // advance the model by one clock, then land 1ns after the next posedge.
  task automatic tick();
    #4;
    obs_wb_ready = oWbReady;
    obs_ll_ready = oLlReady;
    obs_hazard   = oHazard;
    exp_wb_ready = !iRst && iWbValid && (!iLlValid || m_wb_turn);
    exp_ll_ready = !iRst && iLlValid && (!iWbValid || !m_wb_turn);
    exp_hazard   = SB && (m_busy[iReadAddress1] || m_busy[iReadAddress2] ||
                          (iIssueValid && m_busy[iIssueAddr]));
    if (iRst) begin
      model_reset();
    end else begin
      if (iWbValid && iLlValid) m_wb_turn = !m_wb_turn;
      if (exp_wb_ready && iWbAddr != 0) begin
        m_we = 1'b1; m_addr = iWbAddr; m_data = iWbData;
      end else if (exp_ll_ready && iLlAddr != 0) begin
        m_we = 1'b1; m_addr = iLlAddr; m_data = iLlData;
      end else begin
        m_we = 1'b0;
      end
      if (SB && exp_ll_ready && iLlAddr != 0) m_busy[iLlAddr] = 1'b0;
      if (SB && iIssueValid && iIssueAddr != 0) m_busy[iIssueAddr] = 1'b1;
    end
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    iRst = 1'b1;
    iWbValid = 1'b1; iWbAddr = 5'd2; iLlValid = 1'b1; iLlAddr = 5'd3;
    tick();
    n_checks++; if (obs_wb_ready !== 1'b0 || obs_ll_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready: got wb=%b ll=%b want 0 0", obs_wb_ready, obs_ll_ready); end
    idle_inputs();
    tick();
    iRst = 1'b0;
    tick();
    n_checks++; if (oWriteEn !== 1'b0) begin n_fail++;
      $display("FAIL reset_we: got %b want 0", oWriteEn); end
    n_checks++; if (oWriteAddress !== '0 || oDataIn !== '0) begin n_fail++;
      $display("FAIL reset_port: got addr=%0d data=%h want 0 0", oWriteAddress, oDataIn); end
    n_checks++; if (oBusyMask !== '0 || obs_hazard !== 1'b0) begin n_fail++;
      $display("FAIL reset_sb: got mask=%h hazard=%b want 0 0", oBusyMask, obs_hazard); end
    n_checks++; if (obs_wb_ready !== 1'b0 || obs_ll_ready !== 1'b0) begin n_fail++;
      $display("FAIL idle_ready: got wb=%b ll=%b want 0 0", obs_wb_ready, obs_ll_ready); end
  endtask

  task automatic test_wb_only();
    iWbValid = 1'b1; iWbAddr = 5'd5; iWbData = 32'hDEADBEEF;
    tick();
    n_checks++; if (obs_wb_ready !== 1'b1 || obs_ll_ready !== 1'b0) begin n_fail++;
      $display("FAIL wb_only_ready: got wb=%b ll=%b want 1 0", obs_wb_ready, obs_ll_ready); end
    n_checks++; if (oWriteEn !== 1'b1 || oWriteAddress !== 5'd5 || oDataIn !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wb_only_port: got we=%b addr=%0d data=%h want 1 5 deadbeef",
                         oWriteEn, oWriteAddress, oDataIn); end
    idle_inputs();
    tick();
    n_checks++; if (oWriteEn !== 1'b0 || oWriteAddress !== 5'd5 || oDataIn !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL idle_hold: got we=%b addr=%0d data=%h want 0 5 deadbeef",
                         oWriteEn, oWriteAddress, oDataIn); end
  endtask

  task automatic test_contention();
    logic [AW-1:0] want_addr [3];
    logic [DW-1:0] want_data [3];
    want_addr[0] = 5'd3; want_addr[1] = 5'd4; want_addr[2] = 5'd3;
    want_data[0] = 32'h11; want_data[1] = 32'h22; want_data[2] = 32'h11;
    idle_inputs();
    iRst = 1'b1; tick(); iRst = 1'b0;
    iWbValid = 1'b1; iWbAddr = 5'd3; iWbData = 32'h11;
    iLlValid = 1'b1; iLlAddr = 5'd4; iLlData = 32'h22;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (obs_wb_ready !== (c != 1) || obs_ll_ready !== (c == 1)) begin n_fail++;
        $display("FAIL rr_grant%0d: got wb=%b ll=%b want %b %b", c, obs_wb_ready, obs_ll_ready,
                 c != 1, c == 1); end
      n_checks++; if (oWriteEn !== 1'b1 || oWriteAddress !== want_addr[c] ||
                      oDataIn !== want_data[c]) begin n_fail++;
        $display("FAIL rr_port%0d: got we=%b addr=%0d data=%h want 1 %0d %h", c, oWriteEn,
                 oWriteAddress, oDataIn, want_addr[c], want_data[c]); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    iWbValid = 1'b1; iWbAddr = 5'd0; iWbData = 32'h1234;
    tick();
    n_checks++; if (obs_wb_ready !== 1'b1) begin n_fail++;
      $display("FAIL x0_wb_ready: got %b want 1", obs_wb_ready); end
    n_checks++; if (oWriteEn !== 1'b0) begin n_fail++;
      $display("FAIL x0_wb_we: got %b want 0", oWriteEn); end
    idle_inputs();
    iLlValid = 1'b1; iLlAddr = 5'd0; iLlData = 32'h5678;
    tick();
    n_checks++; if (obs_ll_ready !== 1'b1 || oWriteEn !== 1'b0) begin n_fail++;
      $display("FAIL x0_ll: got ready=%b we=%b want 1 0", obs_ll_ready, oWriteEn); end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    logic [NR-1:0] want7;
    want7 = '0; want7[7] = SB;
    idle_inputs();
    iIssueValid = 1'b1; iIssueAddr = 5'd7;
    tick();
    n_checks++; if (obs_hazard !== 1'b0) begin n_fail++;
      $display("FAIL sb_issue_hazard: got %b want 0", obs_hazard); end
    iIssueValid = 1'b0; iReadAddress1 = 5'd7;
    n_checks++; if (oBusyMask !== want7) begin n_fail++;
      $display("FAIL sb_mask_set: got %h want %h", oBusyMask, want7); end
    iLlValid = 1'b1; iLlAddr = 5'd7; iLlData = 32'h77;
    tick();
    n_checks++; if (obs_hazard !== SB || obs_ll_ready !== 1'b1) begin n_fail++;
      $display("FAIL sb_raw_hazard: got hazard=%b ready=%b want %b 1", obs_hazard, obs_ll_ready, SB); end
    iLlValid = 1'b0;
    tick();
    n_checks++; if (obs_hazard !== 1'b0 || oBusyMask !== '0) begin n_fail++;
      $display("FAIL sb_clear: got hazard=%b mask=%h want 0 0", obs_hazard, oBusyMask); end
    iReadAddress1 = 5'd0;
    iIssueValid = 1'b1; iIssueAddr = 5'd7;
    tick();
    iLlValid = 1'b1; iLlAddr = 5'd7; iLlData = 32'h78;
    tick();
    n_checks++; if (obs_hazard !== SB) begin n_fail++;
      $display("FAIL sb_waw_hazard: got %b want %b", obs_hazard, SB); end
    n_checks++; if (oBusyMask !== want7) begin n_fail++;
      $display("FAIL sb_set_wins: got %h want %h", oBusyMask, want7); end
    iIssueValid = 1'b0;
    tick();
    idle_inputs();
    tick();
    n_checks++; if (oBusyMask !== '0) begin n_fail++;
      $display("FAIL sb_final_clear: got %h want 0", oBusyMask); end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] want9;
    want9 = '0; want9[9] = SB;
    idle_inputs();
    iIssueValid = 1'b1; iIssueAddr = 5'd9;
    tick();
    iIssueValid = 1'b0;
    iWbValid = 1'b1; iWbAddr = 5'd10; iWbData = 32'hA;
    iLlValid = 1'b1; iLlAddr = 5'd11; iLlData = 32'hB;
    tick();
    n_checks++; if (oBusyMask !== want9 || oWriteEn !== 1'b1) begin n_fail++;
      $display("FAIL mid_pre: got mask=%h we=%b want %h 1", oBusyMask, oWriteEn, want9); end
    iRst = 1'b1; iReadAddress1 = 5'd9;
    tick();
    n_checks++; if (obs_wb_ready !== 1'b0 || obs_ll_ready !== 1'b0) begin n_fail++;
      $display("FAIL mid_ready: got wb=%b ll=%b want 0 0", obs_wb_ready, obs_ll_ready); end
    n_checks++; if (oWriteEn !== 1'b0 || oWriteAddress !== '0 || oDataIn !== '0 ||
                    oBusyMask !== '0) begin n_fail++;
      $display("FAIL mid_reset: got we=%b addr=%0d data=%h mask=%h want all 0",
               oWriteEn, oWriteAddress, oDataIn, oBusyMask); end
    iRst = 1'b0; iWbValid = 1'b0; iLlValid = 1'b0;
    tick();
    n_checks++; if (obs_hazard !== 1'b0) begin n_fail++;
      $display("FAIL mid_hazard: got %b want 0", obs_hazard); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      iRst = ($urandom_range(0, 59) == 0);
      if (!iWbValid && $urandom_range(0, 2) != 0) begin
        iWbValid = 1'b1; iWbAddr = AW'($urandom); iWbData = $urandom;
      end
      if (!iLlValid && $urandom_range(0, 2) != 0) begin
        iLlValid = 1'b1; iLlAddr = AW'($urandom); iLlData = $urandom;
      end
      a = AW'($urandom);
      iIssueValid = ($urandom_range(0, 3) == 0) && !m_busy[a];
      iIssueAddr = a;
      iReadAddress1 = AW'($urandom);
      iReadAddress2 = AW'($urandom);
      tick();
      n_checks++; if (obs_wb_ready !== exp_wb_ready || obs_ll_ready !== exp_ll_ready) begin n_fail++;
        $display("FAIL rnd_ready c%0d: got wb=%b ll=%b want %b %b", c, obs_wb_ready, obs_ll_ready,
                 exp_wb_ready, exp_ll_ready); end
      n_checks++; if (obs_hazard !== exp_hazard) begin n_fail++;
        $display("FAIL rnd_hazard c%0d: got %b want %b", c, obs_hazard, exp_hazard); end
      n_checks++; if (oWriteEn !== m_we || oWriteAddress !== m_addr || oDataIn !== m_data) begin
        n_fail++; $display("FAIL rnd_port c%0d: got we=%b addr=%0d data=%h want %b %0d %h", c,
                           oWriteEn, oWriteAddress, oDataIn, m_we, m_addr, m_data); end
      n_checks++; if (oBusyMask !== model_mask()) begin n_fail++;
        $display("FAIL rnd_mask c%0d: got %h want %h", c, oBusyMask, model_mask()); end
      if (exp_wb_ready || iRst) iWbValid = 1'b0;
      if (exp_ll_ready || iRst) iLlValid = 1'b0;
    end
    iRst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wb_only();
    test_contention();
    test_x0();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
